// File: rtl/ecc_pkg.sv
// Shared ECC datapath constants and the in-flight tag type used by
// schedulers in front of shared arithmetic units.
package ecc_pkg;

  localparam int unsigned WIDTH = 256;

  localparam logic [WIDTH-1:0] P256 =
    256'hFFFFFFFF_00000001_00000000_00000000_00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } tag_t;

endpackage

// File: rtl/modsub_sched_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after rr, searching
// upward with wrap-around. Produces a one-hot grant and its encoded index.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int unsigned j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(rr) + k) % N;
      if (en && !any && req[j]) begin
        gnt[j] = 1'b1;
        idx    = IW'(j);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/modsub_sched.sv
// Shares one pipelined subMod unit among N_REQ requesters: round-robin issue,
// registered operands, a tag pipe tracking in-flight ops, one-cycle result pulse.
module modsub_sched
  import ecc_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = ecc_pkg::WIDTH,
  parameter int unsigned LAT   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_opA,
  input  logic [N_REQ*WIDTH-1:0] req_opB,
  input  logic [N_REQ*WIDTH-1:0] req_opM,
  input  logic                   hold,
  output logic [WIDTH-1:0]       sub_opA,
  output logic [WIDTH-1:0]       sub_opB,
  output logic [WIDTH-1:0]       sub_opM,
  input  logic [WIDTH-1:0]       sub_out,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   busy
);

  localparam int unsigned RW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [RW-1:0]    rr_q, rr_d;
  logic [N_REQ-1:0] gnt;
  logic [RW-1:0]    gidx;
  logic             gany;

  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] op_m_q, op_m_d;

  tag_t             tag_q [LAT+1];
  tag_t             tag_d [LAT+1];

  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  // Grant only ever lands on an asserted req_valid, so gany doubles as "transfer".
  rr_arbiter #(
    .N  (N_REQ),
    .IW (RW)
  ) u_arb (
    .req (req_valid),
    .rr  (rr_q),
    .en  (~(hold | rst)),
    .gnt (gnt),
    .idx (gidx),
    .any (gany)
  );

  assign req_ready = gnt;

  always_comb begin
    rr_d   = rr_q;
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    op_m_d = op_m_q;
    if (gany) begin
      rr_d = (gidx == RW'(N_REQ - 1)) ? '0 : gidx + RW'(1);
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (gidx == RW'(i)) begin
          op_a_d = req_opA[i*WIDTH +: WIDTH];
          op_b_d = req_opB[i*WIDTH +: WIDTH];
          op_m_d = req_opM[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_comb begin
    tag_d[0].valid = gany;
    tag_d[0].idx   = 3'(gidx);
    for (int unsigned k = 1; k <= LAT; k++) begin
      tag_d[k] = tag_q[k-1];
    end
  end

  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (tag_q[LAT].valid) begin
      rsp_data_d = sub_out;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (tag_q[LAT].idx == 3'(i)) begin
          rsp_valid_d[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    busy = |rsp_valid_q;
    for (int unsigned k = 0; k <= LAT; k++) begin
      busy = busy | tag_q[k].valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q        <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_m_q      <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      for (int unsigned k = 0; k <= LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      rr_q        <= rr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_m_q      <= op_m_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      tag_q       <= tag_d;
    end
  end

  assign sub_opA   = op_a_q;
  assign sub_opB   = op_b_q;
  assign sub_opM   = op_m_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_modsub_sched.sv
// Directed bench for modsub_sched with a 2-stage behavioural subMod and a
// scoreboard of expected {requester, result, grant cycle} entries.
module tb_modsub_sched;

  localparam int unsigned NR = 4;
  localparam int unsigned W  = 256;

  logic             clk = 1'b0;
  logic             rst;
  logic             hold;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*W-1:0]  req_opA, req_opB, req_opM;
  logic [W-1:0]     sub_opA, sub_opB, sub_opM, sub_out;
  logic [NR-1:0]    rsp_valid;
  logic [W-1:0]     rsp_data;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int           idx;
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  exp_t sb [$];
  exp_t mon_e;

  modsub_sched #(
    .N_REQ (NR),
    .WIDTH (W),
    .LAT   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_opA   (req_opA),
    .req_opB   (req_opB),
    .req_opM   (req_opM),
    .hold      (hold),
    .sub_opA   (sub_opA),
    .sub_opB   (sub_opB),
    .sub_opM   (sub_opM),
    .sub_out   (sub_out),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, b, m);
    logic [W:0] t;
    if (a >= b) t = {1'b0, a} - {1'b0, b};
    else        t = {1'b0, a} + {1'b0, m} - {1'b0, b};
    return t[W-1:0];
  endfunction

  // Behavioural subMod: two register stages after the registered operands.
  logic [W-1:0] s1, s2;
  always @(posedge clk) begin
    s1 <= mod_sub(sub_opA, sub_opB, sub_opM);
    s2 <= s1;
  end
  assign sub_out = s2;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push on every transfer, pop and compare on every response.
  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        mon_e.idx  = i;
        mon_e.data = mod_sub(req_opA[i*W +: W], req_opB[i*W +: W], req_opM[i*W +: W]);
        mon_e.cyc  = cyc;
        sb.push_back(mon_e);
      end
    end
    if (rsp_valid != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", W'(rsp_valid), '0);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_valid", W'(rsp_valid), W'(4'b0001 << mon_e.idx));
        check("rsp_data", rsp_data, mon_e.data);
        check("rsp_latency", W'(cyc), W'(mon_e.cyc + 4));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, b, m);
    req_opA[i*W +: W] = a;
    req_opB[i*W +: W] = b;
    req_opM[i*W +: W] = m;
  endtask

  function automatic logic [W-1:0] rnd_below_p();
    logic [W-1:0] v;
    for (int w = 0; w < 8; w++) v[w*32 +: 32] = $urandom;
    v[255:224] = $urandom_range(32'hFFFFFFFE, 0);
    return v;
  endfunction

  task automatic set_rnd(input int i);
    set_op(i, rnd_below_p(), rnd_below_p(), ecc_pkg::P256);
  endtask

  task automatic expect_ready(input string tag, input logic [NR-1:0] exp);
    @(negedge clk);
    check(tag, W'(req_ready), W'(exp));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},    W'(req_ready), '0);
    check({tag, "_rsp_valid"}, W'(rsp_valid), '0);
    check({tag, "_rsp_data"}, rsp_data, '0);
    check({tag, "_sub_opA"},  sub_opA, '0);
    check({tag, "_sub_opB"},  sub_opB, '0);
    check({tag, "_sub_opM"},  sub_opM, '0);
    check({tag, "_busy"},     W'(busy), '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    hold      = 1'b0;
    req_valid = '0;
    req_opA   = '0;
    req_opB   = '0;
    req_opM   = '0;
    step();
    step();
    req_valid = 4'b1111;
    expect_ready("ready_during_rst", 4'b0000);
    step();
    rst       = 1'b0;
    req_valid = '0;
    @(negedge clk);
    check_reset_outputs("reset");

    // Single request from requester 1.
    step();
    set_op(1, 5, 3, 7);
    req_valid = 4'b0010;
    expect_ready("single_grant", 4'b0010);
    step();
    req_valid = '0;
    @(negedge clk);
    check("busy_after_grant", W'(busy), W'(1));
    check("sub_opA_loaded", sub_opA, W'(5));
    check("sub_opB_loaded", sub_opB, W'(3));
    repeat (6) step();

    // Borrow cases; rr is now 2.
    set_op(0, 3, 5, 7);
    req_valid = 4'b0001;
    expect_ready("borrow0_grant", 4'b0001);
    step();
    req_valid = '0;
    set_op(2, 0, 1, ecc_pkg::P256);
    req_valid = 4'b0100;
    expect_ready("borrow2_grant", 4'b0100);
    step();
    req_valid = '0;
    repeat (6) step();

    // rr is 3; one grant to requester 1 leaves rr at 2.
    set_rnd(1);
    req_valid = 4'b0010;
    expect_ready("sparse_prep", 4'b0010);
    step();
    req_valid = '0;

    // Sparse: only 0 and 3 valid with rr=2.
    set_rnd(0);
    set_rnd(3);
    req_valid = 4'b1001;
    expect_ready("sparse_g0", 4'b1000);
    step();
    set_rnd(3);
    expect_ready("sparse_g1", 4'b0001);
    step();
    set_rnd(0);
    expect_ready("sparse_g2", 4'b1000);
    step();
    req_valid = '0;
    repeat (6) step();

    // Fairness: rr is 0, all four valid for 12 cycles.
    for (int i = 0; i < NR; i++) set_rnd(i);
    req_valid = 4'b1111;
    for (int k = 0; k < 12; k++) begin
      expect_ready("fair_grant", 4'b0001 << (k % 4));
      step();
      set_rnd(k % 4);
    end
    req_valid = '0;
    repeat (6) step();

    // hold with two operations in flight.
    set_rnd(0);
    set_rnd(1);
    req_valid = 4'b0011;
    expect_ready("hold_pre0", 4'b0001);
    step();
    set_rnd(0);
    expect_ready("hold_pre1", 4'b0010);
    step();
    set_rnd(1);
    set_rnd(2);
    hold      = 1'b1;
    req_valid = 4'b0111;
    for (int k = 0; k < 5; k++) begin
      expect_ready("hold_ready", 4'b0000);
      step();
    end
    hold = 1'b0;
    expect_ready("hold_rr_kept", 4'b0100);
    step();
    req_valid = 4'b0011;
    expect_ready("hold_post0", 4'b0001);
    step();
    req_valid = 4'b0010;
    expect_ready("hold_post1", 4'b0010);
    step();
    req_valid = '0;
    repeat (6) step();

    // Reset mid-flight; rr is 2 before reset.
    set_rnd(1);
    set_rnd(2);
    req_valid = 4'b0110;
    expect_ready("rst_pre0", 4'b0100);
    step();
    req_valid = 4'b0010;
    expect_ready("rst_pre1", 4'b0010);
    step();
    rst       = 1'b1;
    req_valid = 4'b1111;
    sb.delete();
    expect_ready("rst_pulse_ready", 4'b0000);
    step();
    rst       = 1'b0;
    req_valid = '0;
    @(negedge clk);
    check_reset_outputs("after_rst");
    repeat (5) step();
    for (int i = 0; i < 3; i++) set_rnd(i);
    req_valid = 4'b0111;
    expect_ready("post_rst_grant", 4'b0001);
    step();
    req_valid = '0;
    repeat (8) step();

    @(negedge clk);
    check("final_busy", W'(busy), '0);
    check("sb_drained", W'(sb.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/modsub_sched.md
# modsub_sched

Round-robin scheduler that shares one pipelined `subMod` modular-subtraction unit among `N_REQ` requesters, such as point-add, point-double and inversion engines. It sits between the requesters and the single `subMod` instance. It accepts operand triples through per-requester valid/ready handshakes, issues at most one operation per cycle, and tracks in-flight operations with a tag pipeline. Each result is returned to its originating requester with a one-cycle valid pulse.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 1..8.
- `WIDTH`, 256: operand and result width.
- `LAT`, 2: `subMod` latency in clock edges from operands applied to `out_data` valid. 0 means combinational.

Ports:
- `clk` in 1: the single clock. Every flop uses its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in `N_REQ`: requester i presents an operation.
- `req_ready` out `N_REQ`: grant, one-hot or zero.
- `req_opA` in `N_REQ*WIDTH`: minuends. Slice i belongs to requester i.
- `req_opB` in `N_REQ*WIDTH`: subtrahends.
- `req_opM` in `N_REQ*WIDTH`: moduli.
- `hold` in 1: while high, no new grants are issued.
- `sub_opA` out `WIDTH`: registered operand A to `subMod`.
- `sub_opB` out `WIDTH`: registered operand B to `subMod`.
- `sub_opM` out `WIDTH`: registered modulus to `subMod`.
- `sub_out` in `WIDTH`: `subMod` `out_data`.
- `rsp_valid` out `N_REQ`: one-hot result pulse.
- `rsp_data` out `WIDTH`: result, broadcast to all requesters and qualified by `rsp_valid`.
- `busy` out 1: high while any operation is in flight.

## Operation
- **Handshake.** A transfer occurs on any edge where `req_valid[i] & req_ready[i]` is high.
  - A requester must hold `req_valid` and its operand slice stable until the transfer.
  - `req_valid` must not depend on `req_ready`.
- **Arbitration.** A round-robin pointer `rr` (log2 `N_REQ` bits) selects the winner.
  - The winner is the first asserted `req_valid` at or after index `rr`, searching upward with wrap-around.
  - `req_ready` is combinational from `req_valid`, `rr` and `hold`. It is all-zero while `hold` or `rst` is high.
  - After a grant to index g, `rr` becomes (g+1) mod `N_REQ`. `rr` is unchanged when there is no grant.
- **Issue.** On a transfer edge, the winner's operand slice loads into `sub_opA`, `sub_opB` and `sub_opM`.
  - With no transfer, these registers hold their previous values, to suppress toggling.
- **Tag pipe.** The pipe has `LAT`+1 stages, each carrying {valid, index}.
  - Stage 0 loads {transfer, g} on every edge.
  - Each stage shifts one position per edge.
  - The stage-`LAT` output qualifies `sub_out`.
- **Response.** When the last tag stage is valid, `rsp_data` registers `sub_out` and `rsp_valid[index]` pulses for one cycle.
  - Requesters cannot backpressure: they must accept the response in that cycle.
- **busy.** `busy` is the OR of all tag valids and `rsp_valid`.
- **Arithmetic.** All arithmetic is performed by `subMod`. This block never alters the data.
  - Operands must satisfy opA, opB < opM. Results for operands outside that range are passed through unchecked.

## Timing
- **Reset values.** `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `sub_op*`=0, `rr`=0, all tag valids=0, `busy`=0.
- **Latency.** With the transfer on edge E, `rsp_valid` is high during the cycle after edge E+`LAT`+1. That is `LAT`+2 cycles from the grant cycle.
- **Throughput.** One operation per cycle, sustained. There is no stall path.
- **Simultaneous requests.** All `N_REQ` requesters valid continuously produces grants 0,1,2,3,0,… on consecutive cycles.
- **Responses** leave in strict issue order.
- **hold mid-stream.** In-flight operations complete and their responses are delivered. Asserting `hold` does not move `rr`.
- **rst mid-operation.** The tag pipe is cleared, so in-flight operations produce no `rsp_valid`, ever. Requesters must reissue.
- **N_REQ=1.** `rr` is a constant 0, and `req_ready`=`req_valid` & ~`hold`.

## Structure
- The shared package `ecc_pkg` holds:
  - the `WIDTH` constant, 256;
  - the `P256` prime constant;
  - the typedef `tag_t` = {valid, idx[2:0]}.
- One sub-module: `rr_arbiter`. It takes `req`, `rr` and `en` and produces a one-hot grant plus the encoded index, which makes it reusable for other shared ECC units.
- Tag pipe, operand registers and response register live in `modsub_sched` itself.

## Test plan
All scenarios run with `LAT`=2 and a behavioural `subMod` model.
- **Single request.** Requester 1 issues opA=5, opB=3, opM=7 → `rsp_valid`=0010 with `rsp_data`=2, exactly 4 cycles after the grant cycle.
- **Borrow case.** Requester 0 issues opA=3, opB=5, opM=7 → `rsp_data`=5. Requester 2 issues opA=0, opB=1, opM=`P256` → `rsp_data`=`P256`−1.
- **Fairness.** All four requesters are held valid for 12 cycles → grants follow 0,1,2,3 ×3. Responses arrive back-to-back in the same order, each with the matching data.
- **Sparse requests.** `rr`=2 with only requesters 0 and 3 valid → grant to 3, then 0, then 3.
- **hold.** Assert `hold` for 5 cycles with 2 operations in flight → both responses still arrive. `req_ready` stays 0 throughout, and `rr` is unchanged.
- **Reset mid-flight.** Pulse `rst` one cycle after two grants → no `rsp_valid` appears. All outputs are at reset values the next cycle, and a new request afterwards is granted to index 0 and completes normally.
